// File: rtl/trap_ctrl.sv
// trap_ctrl: trap arbitration and PC-redirect sequencer feeding the mepc/sepc CSR block.
// Picks the winning interrupt or exception at the commit boundary, applies delegation and
// privilege/enable rules, then runs flush -> drain -> commit -> redirect. Also redirects
// mret/sret to mepc/sepc.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ins_valid/ins_pc/ins_retire commit-boundary instruction status
//   exc_vec, irq_pend           exception flags / pending+enabled interrupts (bit = code)
//   priv, mstatus_mie/sie       current privilege and global interrupt enables
//   medeleg, mideleg            exception / interrupt delegation masks
//   mret, sret                  xRET at the commit boundary
//   mtvec, stvec, mepc, sepc    trap vectors and return PCs
//   pipe_idle, redirect_ready   pipeline drained / fetch accepts redirect
//   flush                       one-cycle kill of younger instructions
//   trap_target_m/_s            one-cycle commit pulse to the EPC block
//   next_pc, trap_pc, cause     latched trap information for the EPC block
//   pc_jmp                      tied 0
//   redirect_valid/redirect_pc  redirect request to fetch
//   busy                        sequencer not idle
module trap_ctrl #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ins_valid,
    input  logic [XLEN-1:0] ins_pc,
    input  logic            ins_retire,
    input  logic [15:0]     exc_vec,
    input  logic [15:0]     irq_pend,
    input  logic [1:0]      priv,
    input  logic            mstatus_mie,
    input  logic            mstatus_sie,
    input  logic [15:0]     medeleg,
    input  logic [15:0]     mideleg,
    input  logic            mret,
    input  logic            sret,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    input  logic            pipe_idle,
    input  logic            redirect_ready,
    output logic            flush,
    output logic            trap_target_m,
    output logic            trap_target_s,
    output logic            next_pc,
    output logic            pc_jmp,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] cause,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned IRQ_N  = 6;
    localparam int unsigned EXC_N  = 14;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [CODE_W-1:0] ILLEGAL_INSN = 4'd2;

    // Highest priority first.
    localparam logic [CODE_W-1:0] IRQ_PRIO [IRQ_N] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};
    localparam logic [CODE_W-1:0] EXC_PRIO [EXC_N] = '{4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9,
                                                       4'd11, 4'd5, 4'd7, 4'd13, 4'd15, 4'd4, 4'd6};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2,
        REDIR  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              tgt_s, tgt_s_d;
    logic              flush_d, trap_target_m_d, trap_target_s_d, next_pc_d;
    logic              redirect_valid_d, busy_d;
    logic [XLEN-1:0]   trap_pc_d, cause_d, redirect_pc_d;

    logic              irq_hit, irq_s, irq_del, irq_en;
    logic [CODE_W-1:0] irq_code, irq_c;
    logic              exc_hit, exc_s;
    logic [CODE_W-1:0] exc_code, exc_c;
    logic              ill_sret;
    logic [XLEN-1:0]   tvec, tvec_base, vec_off;

    assign pc_jmp = 1'b0;

    // Interrupt pick: scan lowest priority first so the highest enabled one wins.
    // A delegated interrupt while in M evaluates as disabled.
    always_comb begin
        irq_hit  = 1'b0;
        irq_s    = 1'b0;
        irq_code = '0;
        irq_c    = '0;
        irq_del  = 1'b0;
        irq_en   = 1'b0;
        for (int k = IRQ_N - 1; k >= 0; k--) begin
            irq_c   = IRQ_PRIO[k];
            irq_del = mideleg[irq_c];
            irq_en  = irq_del ? ((priv == PRIV_U) || ((priv == PRIV_S) && mstatus_sie))
                              : ((priv != PRIV_M) || mstatus_mie);
            if (irq_pend[irq_c] && irq_en) begin
                irq_hit  = 1'b1;
                irq_s    = irq_del;
                irq_code = irq_c;
            end
        end
    end

    // Exception pick, same scan order trick.
    always_comb begin
        exc_hit  = 1'b0;
        exc_code = '0;
        exc_c    = '0;
        for (int k = EXC_N - 1; k >= 0; k--) begin
            exc_c = EXC_PRIO[k];
            if (exc_vec[exc_c]) begin
                exc_hit  = 1'b1;
                exc_code = exc_c;
            end
        end
        exc_s = medeleg[exc_code] && (priv != PRIV_M);
    end

    assign ill_sret = sret && (priv == PRIV_U);

    // Vector target; only interrupts in mode 1 are vectored, other modes are direct.
    assign tvec      = tgt_s ? stvec : mtvec;
    assign tvec_base = {tvec[XLEN-1:2], 2'b00};
    assign vec_off   = ((tvec[1:0] == 2'd1) && cause[XLEN-1]) ? XLEN'({cause[5:0], 2'b00}) : '0;

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        tgt_s_d         = tgt_s;
        flush_d         = 1'b0;
        trap_target_m_d = 1'b0;
        trap_target_s_d = 1'b0;
        next_pc_d       = next_pc;
        trap_pc_d       = trap_pc;
        cause_d         = cause;
        redirect_pc_d   = redirect_pc;

        case (state)
            IDLE: begin
                if (ins_valid) begin
                    if (irq_hit) begin
                        cause_d   = {1'b1, (XLEN-1)'(irq_code)};
                        tgt_s_d   = irq_s;
                        next_pc_d = ins_retire;
                        trap_pc_d = ins_pc;
                        flush_d   = 1'b1;
                        cnt_d     = '0;
                        state_d   = DRAIN;
                    end else if (exc_hit || ill_sret) begin
                        cause_d   = exc_hit ? XLEN'(exc_code) : XLEN'(ILLEGAL_INSN);
                        tgt_s_d   = exc_hit ? exc_s : (medeleg[ILLEGAL_INSN] && (priv != PRIV_M));
                        next_pc_d = 1'b0;
                        trap_pc_d = ins_pc;
                        flush_d   = 1'b1;
                        cnt_d     = '0;
                        state_d   = DRAIN;
                    end else if (mret || sret) begin
                        redirect_pc_d = mret ? mepc : sepc;
                        flush_d       = 1'b1;
                        state_d       = REDIR;
                    end
                end
            end
            DRAIN: begin
                if (pipe_idle || (cnt == CNT_W'(DRAIN_MAX))) begin
                    trap_target_m_d = !tgt_s;
                    trap_target_s_d = tgt_s;
                    state_d         = COMMIT;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            COMMIT: begin
                redirect_pc_d = tvec_base + vec_off;
                state_d       = REDIR;
            end
            REDIR: begin
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        redirect_valid_d = (state_d == REDIR);
        busy_d           = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            tgt_s          <= 1'b0;
            flush          <= 1'b0;
            trap_target_m  <= 1'b0;
            trap_target_s  <= 1'b0;
            next_pc        <= 1'b0;
            trap_pc        <= '0;
            cause          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            tgt_s          <= tgt_s_d;
            flush          <= flush_d;
            trap_target_m  <= trap_target_m_d;
            trap_target_s  <= trap_target_s_d;
            next_pc        <= next_pc_d;
            trap_pc        <= trap_pc_d;
            cause          <= cause_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl. Expected trap records are queued when a
// trap is stimulated and popped when the DUT raises its commit pulse.
module tb_trap_ctrl;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TMO  = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic            ins_valid, ins_retire, mstatus_mie, mstatus_sie, mret, sret;
    logic [XLEN-1:0] ins_pc, mtvec, stvec, mepc, sepc;
    logic [15:0]     exc_vec, irq_pend, medeleg, mideleg;
    logic [1:0]      priv;
    logic            pipe_idle, redirect_ready;
    logic            flush, trap_target_m, trap_target_s, next_pc, pc_jmp, redirect_valid, busy;
    logic [XLEN-1:0] trap_pc, cause, redirect_pc;

    typedef struct {
        logic            m;
        logic            s;
        logic            npc;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tpc;
        logic [XLEN-1:0] rpc;
        int              lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .DRAIN_MAX(15)) dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_pc(ins_pc), .ins_retire(ins_retire),
        .exc_vec(exc_vec), .irq_pend(irq_pend), .priv(priv), .mstatus_mie(mstatus_mie),
        .mstatus_sie(mstatus_sie), .medeleg(medeleg), .mideleg(mideleg), .mret(mret),
        .sret(sret), .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
        .pipe_idle(pipe_idle), .redirect_ready(redirect_ready), .flush(flush),
        .trap_target_m(trap_target_m), .trap_target_s(trap_target_s), .next_pc(next_pc),
        .pc_jmp(pc_jmp), .trap_pc(trap_pc), .cause(cause), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    task automatic idle_inputs();
        ins_valid = 0; ins_pc = '0; ins_retire = 0; exc_vec = '0; irq_pend = '0; priv = 2'd0;
        mstatus_mie = 0; mstatus_sie = 0; medeleg = '0; mideleg = '0; mret = 0; sret = 0;
        mtvec = '0; stvec = '0; mepc = '0; sepc = '0; pipe_idle = 1; redirect_ready = 1;
    endtask

    // Present the instruction for one clock edge; returns at the negedge after it.
    task automatic fire();
        @(negedge clk); ins_valid = 1;
        @(negedge clk); ins_valid = 0; exc_vec = '0; irq_pend = '0; mret = 0; sret = 0;
    endtask

    task automatic wait_pulse(output int cyc);
        cyc = 0;
        while (!(trap_target_m || trap_target_s) && cyc < TMO) begin @(negedge clk); cyc++; end
    endtask

    task automatic wait_redir(output int cyc);
        cyc = 0;
        while (!redirect_valid && cyc < TMO) begin @(negedge clk); cyc++; end
    endtask

    task automatic test_reset();
        idle_inputs(); rst = 1;
        repeat (3) @(negedge clk);
        n_checks++; if ({flush, trap_target_m, trap_target_s, next_pc, pc_jmp, redirect_valid, busy} !== 7'd0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0", {flush, trap_target_m, trap_target_s, next_pc, pc_jmp, redirect_valid, busy}); end
        n_checks++; if (trap_pc !== '0) begin n_fail++; $display("FAIL reset_trap_pc: got %h want 0", trap_pc); end
        n_checks++; if (cause !== '0) begin n_fail++; $display("FAIL reset_cause: got %h want 0", cause); end
        n_checks++; if (redirect_pc !== '0) begin n_fail++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
        rst = 0;
    endtask

    task automatic test_irq_vectored();
        int cyc;
        idle_inputs(); priv = 2'd0; irq_pend[7] = 1; ins_pc = 64'h8000_0100; ins_retire = 1;
        mtvec = 64'h8000_0001;
        sb.push_back('{m: 1, s: 0, npc: 1, cause: 64'h8000_0000_0000_0007, tpc: 64'h8000_0100, rpc: 64'h8000_001C, lat: 1});
        fire();
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL irq_flush: got %b want 1", flush); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL irq_busy: got %b want 1", busy); end
        wait_pulse(cyc);
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL irq_flush_len: got %b want 0", flush); end
        e = sb.pop_front();
        n_checks++; if (cyc !== e.lat) begin n_fail++; $display("FAIL irq_latency: got %0d want %0d", cyc, e.lat); end
        n_checks++; if ({trap_target_m, trap_target_s} !== {e.m, e.s}) begin n_fail++; $display("FAIL irq_target: got %b want %b", {trap_target_m, trap_target_s}, {e.m, e.s}); end
        n_checks++; if (next_pc !== e.npc) begin n_fail++; $display("FAIL irq_next_pc: got %b want %b", next_pc, e.npc); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL irq_cause: got %h want %h", cause, e.cause); end
        n_checks++; if (trap_pc !== e.tpc) begin n_fail++; $display("FAIL irq_trap_pc: got %h want %h", trap_pc, e.tpc); end
        wait_redir(cyc);
        n_checks++; if ({trap_target_m, trap_target_s} !== 2'b00) begin n_fail++; $display("FAIL irq_pulse_len: got %b want 00", {trap_target_m, trap_target_s}); end
        n_checks++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL irq_rpc: got %h want %h", redirect_pc, e.rpc); end
        @(negedge clk);
        n_checks++; if ({redirect_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL irq_done: got %b want 00", {redirect_valid, busy}); end
    endtask

    task automatic test_exc_deleg();
        int cyc;
        idle_inputs(); priv = 2'd1; exc_vec = 16'h1004; medeleg[12] = 1; ins_pc = 64'h8000_2000;
        ins_retire = 1; stvec = 64'h8020_0000; mtvec = 64'h8000_0000;
        sb.push_back('{m: 0, s: 1, npc: 0, cause: 64'd12, tpc: 64'h8000_2000, rpc: 64'h8020_0000, lat: 1});
        fire();
        wait_pulse(cyc);
        e = sb.pop_front();
        n_checks++; if ({trap_target_m, trap_target_s} !== {e.m, e.s}) begin n_fail++; $display("FAIL exc_target: got %b want %b", {trap_target_m, trap_target_s}, {e.m, e.s}); end
        n_checks++; if (next_pc !== e.npc) begin n_fail++; $display("FAIL exc_next_pc: got %b want %b", next_pc, e.npc); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL exc_cause: got %h want %h", cause, e.cause); end
        n_checks++; if (pc_jmp !== 1'b0) begin n_fail++; $display("FAIL exc_pc_jmp: got %b want 0", pc_jmp); end
        wait_redir(cyc);
        n_checks++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL exc_rpc: got %h want %h", redirect_pc, e.rpc); end
        @(negedge clk);
    endtask

    // Cases where nothing must be taken.
    task automatic test_masked();
        logic seen;
        seen = 0;
        idle_inputs(); priv = 2'd3; irq_pend[9] = 1; mideleg[9] = 1; mstatus_sie = 1; mstatus_mie = 1;
        @(negedge clk); ins_valid = 1;
        repeat (4) begin @(negedge clk); seen |= busy | flush; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mask_m_deleg: got busy/flush %b want 0", seen); end
        seen = 0; ins_valid = 0; priv = 2'd1; mstatus_sie = 0;
        @(negedge clk); ins_valid = 1;
        repeat (4) begin @(negedge clk); seen |= busy | flush; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mask_s_sie: got busy/flush %b want 0", seen); end
        seen = 0; ins_valid = 0; irq_pend = '0; exc_vec = 16'h0004;
        repeat (4) begin @(negedge clk); seen |= busy | flush; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mask_no_valid: got busy/flush %b want 0", seen); end
        idle_inputs();
    endtask

    task automatic test_irq_over_exc();
        int cyc;
        idle_inputs(); priv = 2'd0; irq_pend[11] = 1; exc_vec[2] = 1; ins_pc = 64'h8000_3000;
        ins_retire = 0; mtvec = 64'h8000_0002;
        sb.push_back('{m: 1, s: 0, npc: 0, cause: {1'b1, 63'd11}, tpc: 64'h8000_3000, rpc: 64'h8000_0000, lat: 1});
        fire();
        wait_pulse(cyc);
        e = sb.pop_front();
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL prio_cause: got %h want %h", cause, e.cause); end
        n_checks++; if ({trap_target_m, trap_target_s, next_pc} !== {e.m, e.s, e.npc}) begin n_fail++; $display("FAIL prio_flags: got %b want %b", {trap_target_m, trap_target_s, next_pc}, {e.m, e.s, e.npc}); end
        wait_redir(cyc);
        n_checks++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL prio_rpc_mode2: got %h want %h", redirect_pc, e.rpc); end
        @(negedge clk);
    endtask

    task automatic test_s_vectored();
        int cyc;
        idle_inputs(); priv = 2'd1; mstatus_sie = 1; irq_pend[5] = 1; irq_pend[9] = 1;
        mideleg[5] = 1; mideleg[9] = 1; ins_pc = 64'h8000_4000; ins_retire = 1; stvec = 64'h8030_0001;
        sb.push_back('{m: 0, s: 1, npc: 1, cause: {1'b1, 63'd9}, tpc: 64'h8000_4000, rpc: 64'h8030_0024, lat: 1});
        fire();
        wait_pulse(cyc);
        e = sb.pop_front();
        n_checks++; if ({trap_target_m, trap_target_s} !== {e.m, e.s}) begin n_fail++; $display("FAIL svec_target: got %b want %b", {trap_target_m, trap_target_s}, {e.m, e.s}); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL svec_cause: got %h want %h", cause, e.cause); end
        wait_redir(cyc);
        n_checks++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL svec_rpc: got %h want %h", redirect_pc, e.rpc); end
        @(negedge clk);
    endtask

    task automatic test_drain_timeout();
        int cyc;
        idle_inputs(); priv = 2'd0; exc_vec[8] = 1; ins_pc = 64'h8000_5000; ins_retire = 1;
        mtvec = 64'h8000_0001; pipe_idle = 0;
        sb.push_back('{m: 1, s: 0, npc: 0, cause: 64'd8, tpc: 64'h8000_5000, rpc: 64'h8000_0000, lat: 16});
        fire();
        wait_pulse(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.lat) begin n_fail++; $display("FAIL drain_latency: got %0d want %0d", cyc, e.lat); end
        n_checks++; if ({trap_target_m, next_pc, cause} !== {e.m, e.npc, e.cause}) begin n_fail++; $display("FAIL drain_commit: got %b/%b/%h want %b/%b/%h", trap_target_m, next_pc, cause, e.m, e.npc, e.cause); end
        wait_redir(cyc);
        n_checks++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL drain_rpc_exc_direct: got %h want %h", redirect_pc, e.rpc); end
        @(negedge clk);
    endtask

    task automatic test_sret_illegal();
        int cyc;
        idle_inputs(); priv = 2'd0; sret = 1; sepc = 64'h8000_0900; ins_pc = 64'h8000_6000;
        ins_retire = 1; mtvec = 64'h8000_0000;
        sb.push_back('{m: 1, s: 0, npc: 0, cause: 64'd2, tpc: 64'h8000_6000, rpc: 64'h8000_0000, lat: 1});
        fire();
        wait_pulse(cyc);
        e = sb.pop_front();
        n_checks++; if ({trap_target_m, trap_target_s, next_pc} !== {e.m, e.s, e.npc}) begin n_fail++; $display("FAIL sret_ill_flags: got %b want %b", {trap_target_m, trap_target_s, next_pc}, {e.m, e.s, e.npc}); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL sret_ill_cause: got %h want %h", cause, e.cause); end
        n_checks++; if (trap_pc !== e.tpc) begin n_fail++; $display("FAIL sret_ill_trap_pc: got %h want %h", trap_pc, e.tpc); end
        wait_redir(cyc);
        n_checks++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL sret_ill_rpc: got %h want %h", redirect_pc, e.rpc); end
        @(negedge clk);
    endtask

    task automatic test_mret_backpressure();
        logic pulse_seen, held;
        pulse_seen = 0; held = 1;
        idle_inputs(); priv = 2'd3; mret = 1; mepc = 64'h8000_0400; redirect_ready = 0;
        fire();
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mret_flush: got %b want 1", flush); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            pulse_seen |= trap_target_m | trap_target_s;
            held &= redirect_valid & (redirect_pc == 64'h8000_0400);
        end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL mret_hold: got valid=%b pc=%h want 1/8000000000000400", redirect_valid, redirect_pc); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL mret_flush_len: got %b want 0", flush); end
        redirect_ready = 1;
        @(negedge clk);
        pulse_seen |= trap_target_m | trap_target_s;
        n_checks++; if ({redirect_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL mret_accept: got %b want 00", {redirect_valid, busy}); end
        n_checks++; if (pulse_seen !== 1'b0) begin n_fail++; $display("FAIL mret_no_pulse: got %b want 0", pulse_seen); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        idle_inputs(); priv = 2'd1; sret = 1; sepc = 64'h8000_0800;
        fire();
        n_checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 64'h8000_0800}) begin n_fail++; $display("FAIL sret_rpc: got %b/%h want 1/8000000000000800", redirect_valid, redirect_pc); end
        idle_inputs(); priv = 2'd0; exc_vec[0] = 1; exc_vec[4] = 1; ins_pc = 64'h8000_7000; mtvec = 64'h8000_0100;
        sb.push_back('{m: 1, s: 0, npc: 0, cause: 64'd0, tpc: 64'h8000_7000, rpc: 64'h8000_0100, lat: 1});
        fire();
        wait_pulse(cyc);
        e = sb.pop_front();
        n_checks++; if ({cause, trap_pc} !== {e.cause, e.tpc}) begin n_fail++; $display("FAIL b2b_cause_pc: got %h/%h want %h/%h", cause, trap_pc, e.cause, e.tpc); end
        wait_redir(cyc);
        n_checks++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL b2b_rpc: got %h want %h", redirect_pc, e.rpc); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_redir();
        idle_inputs(); priv = 2'd3; mret = 1; mepc = 64'h8000_0440; redirect_ready = 0;
        fire();
        @(negedge clk); rst = 1;
        @(negedge clk);
        n_checks++; if ({flush, trap_target_m, trap_target_s, next_pc, redirect_valid, busy} !== 6'd0) begin n_fail++; $display("FAIL rst_redir_ctl: got %b want 0", {flush, trap_target_m, trap_target_s, next_pc, redirect_valid, busy}); end
        n_checks++; if ({trap_pc, cause, redirect_pc} !== '0) begin n_fail++; $display("FAIL rst_redir_data: got %h/%h/%h want 0", trap_pc, cause, redirect_pc); end
        rst = 0; redirect_ready = 1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_redir_idle: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_irq_vectored();
        test_exc_deleg();
        test_masked();
        test_irq_over_exc();
        test_s_vectored();
        test_drain_timeout();
        test_sret_illegal();
        test_mret_backpressure();
        test_back_to_back();
        test_reset_in_redir();
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
